// File: rtl/rotate_sequencer_if.sv
// Bundle between rotate_sequencer, its requester and the external 4-bit rotator.
// The master side stands for the requester and also supplies the rotator result.
interface rotate_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [3:0]       data_in;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic [3:0]       rot_a;
  logic [1:0]       rot_shift;
  logic [3:0]       rot_y;
  logic             busy;
  logic             done;
  logic [3:0]       result;

  modport master (
    output start, data_in, count, dir, rot_y,
    input  rot_a, rot_shift, busy, done, result
  );

  modport slave (
    input  start, data_in, count, dir, rot_y,
    output rot_a, rot_shift, busy, done, result
  );
endinterface

// File: rtl/rotate_sequencer.sv
// Multi-cycle rotate controller: feeds an external 0..3 right rotator repeatedly
// until the requested count is consumed, then pulses done with the final word.
module rotate_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rotate_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_word;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir_q;
  logic [3:0]       r_result;

  logic [1:0]       w_step;
  logic [CNT_W-1:0] w_rem_next;
  logic [1:0]       w_run_shift;

  // Step size is capped at 3 because the rotator only reaches 0..3 positions.
  always_comb begin
    w_step = 2'd0;
    if (r_rem >= CNT_W'(3)) w_step = 2'd3;
    else                    w_step = r_rem[1:0];
  end

  assign w_rem_next  = r_rem - CNT_W'(w_step);
  // A left rotate by k is the same as a right rotate by (4-k) mod 4.
  assign w_run_shift = r_dir_q ? 2'(2'd0 - w_step) : w_step;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_rem_next == '0) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word   <= 4'd0;
      r_rem    <= '0;
      r_dir_q  <= 1'b0;
      r_result <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_word  <= bus.data_in;
            r_rem   <= bus.count;
            r_dir_q <= bus.dir;
            // A zero count goes straight to DONE, so result is the captured word.
            if (bus.count == '0) r_result <= bus.data_in;
          end
        end
        S_RUN: begin
          r_word <= bus.rot_y;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) r_result <= bus.rot_y;
        end
        default: ;
      endcase
    end
  end

  assign bus.rot_a     = r_word;
  assign bus.rot_shift = (r_state == S_RUN) ? w_run_shift : 2'd0;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;

endmodule
